slave_port_arbiter: RTL and testbench

//  One per slave port of cross_bar. Shares a single slave between NUM_MASTERS masters.

---
 rtl/slave_port_arbiter_pkg.sv | 11 +
 rtl/slave_port_arbiter_rr_pick.sv | 24 ++
 rtl/slave_port_arbiter.sv | 83 ++++++++
 tb/tb_slave_port_arbiter.sv | 138 +++++++++++++
 4 files changed

// File: rtl/slave_port_arbiter_pkg.sv
// slave_port_arbiter_pkg: shared FSM encodings, command codes and error code for the crossbar slave ports
package slave_port_arbiter_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2} state_t;
  localparam logic CMD_READ = 1'b0;
  localparam logic CMD_WRITE = 1'b1;
  localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;
  localparam int DEF_MASTERS = 2;
  localparam int DEF_AW = 32;
  localparam int DEF_DW = 32;
  localparam int DEF_TIMEOUT = 16;
endpackage

// File: rtl/slave_port_arbiter_rr_pick.sv
// slave_port_arbiter_rr_pick: combinational round-robin picker starting one past the last winner
module slave_port_arbiter_rr_pick #(
  parameter int N = 2,
  parameter int LW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [LW-1:0] last,
  output logic [N-1:0]  grant,
  output logic [LW-1:0] idx,
  output logic          any
);
  int j;
  always_comb begin
    j = 0;
    idx = '0;
    // descending scan so the closest requester after last is written last and wins
    for (int k = N; k >= 1; k--) begin
      j = (int'(last) + k) % N;
      if (req[j]) idx = LW'(j);
    end
    any = |req;
    grant = any ? N'(1) << idx : '0;
  end
endmodule

// File: rtl/slave_port_arbiter.sv
// slave_port_arbiter: shares one slave between masters with round-robin grants and a completion watchdog
module slave_port_arbiter
  import slave_port_arbiter_pkg::*;
#(
  parameter int NUM_MASTERS = DEF_MASTERS,
  parameter int AW = DEF_AW,
  parameter int DW = DEF_DW,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_MASTERS-1:0]    m_req,
  input  logic [NUM_MASTERS*AW-1:0] m_addr,
  input  logic [NUM_MASTERS-1:0]    m_cmd,
  input  logic [NUM_MASTERS*DW-1:0] m_wdata,
  output logic [NUM_MASTERS-1:0]    m_ack,
  output logic [DW-1:0]             m_rdata,
  output logic                      m_err,
  output logic                      slv_req,
  output logic [AW-1:0]             slv_addr,
  output logic                      slv_cmd,
  output logic [DW-1:0]             slv_wdata,
  input  logic                      slv_ack,
  input  logic [DW-1:0]             slv_rdata
);
  localparam int LW = $clog2(NUM_MASTERS);
  localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);
  state_t state;
  logic [NUM_MASTERS-1:0] grant, pick_grant;
  logic [LW-1:0] last, pick_idx;
  logic pick_any, expire;
  logic [CW-1:0] wd_cnt;
  slave_port_arbiter_rr_pick #(.N(NUM_MASTERS), .LW(LW)) u_pick (
    .req  (m_req),
    .last (last),
    .grant(pick_grant),
    .idx  (pick_idx),
    .any  (pick_any)
  );
  assign expire = (TIMEOUT != 0) && (wd_cnt == LAST_CNT);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      grant <= '0;
      last <= LW'(NUM_MASTERS - 1);
      wd_cnt <= '0;
      m_ack <= '0;
      m_rdata <= '0;
      m_err <= 1'b0;
      slv_req <= 1'b0;
      slv_addr <= '0;
      slv_cmd <= CMD_READ;
      slv_wdata <= '0;
    end else begin
      m_ack <= '0;
      case (state)
        IDLE: if (pick_any) begin
          state <= BUSY;
          grant <= pick_grant;
          last <= pick_idx;
          wd_cnt <= '0;
          slv_req <= 1'b1;
          slv_addr <= m_addr[pick_idx*AW +: AW];
          slv_cmd <= m_cmd[pick_idx];
          slv_wdata <= m_wdata[pick_idx*DW +: DW];
        end
        // ack beats expiry when both land in the same cycle
        BUSY: if (slv_ack || expire) begin
          state <= RESP;
          slv_req <= 1'b0;
          m_ack <= grant;
          m_rdata <= slv_ack ? slv_rdata : DW'(ERR_DATA);
          m_err <= !slv_ack;
        end else begin
          wd_cnt <= wd_cnt + CW'(!(&wd_cnt));
        end
        RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_slave_port_arbiter.sv
// tb_slave_port_arbiter: directed checks of grant rotation, data return, watchdog and reset abandonment
module tb_slave_port_arbiter;
  logic clk = 1'b0;
  logic reset;
  logic [1:0] m_req, m_cmd, m_ack;
  logic [63:0] m_addr, m_wdata;
  logic [31:0] m_rdata, slv_addr, slv_wdata, slv_rdata;
  logic m_err, slv_req, slv_cmd, slv_ack;
  int tests = 0;
  int fails = 0;
  localparam logic [31:0] A0 = 32'h1000_0000;
  localparam logic [31:0] A1 = 32'h2000_0004;
  localparam logic [31:0] W0 = 32'h0000_AAAA;
  localparam logic [31:0] W1 = 32'h0000_BBBB;
  slave_port_arbiter #(.NUM_MASTERS(2), .AW(32), .DW(32), .TIMEOUT(16)) dut (
    .clk      (clk),
    .reset    (reset),
    .m_req    (m_req),
    .m_addr   (m_addr),
    .m_cmd    (m_cmd),
    .m_wdata  (m_wdata),
    .m_ack    (m_ack),
    .m_rdata  (m_rdata),
    .m_err    (m_err),
    .slv_req  (slv_req),
    .slv_addr (slv_addr),
    .slv_cmd  (slv_cmd),
    .slv_wdata(slv_wdata),
    .slv_ack  (slv_ack),
    .slv_rdata(slv_rdata)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(negedge clk);
  endtask
  task automatic serve(input int mst, input logic [31:0] addr, input logic [31:0] rd);
    step();
    chk("busy_slv_req", 64'(slv_req), 64'd1);
    chk("busy_slv_addr", 64'(slv_addr), 64'(addr));
    slv_ack = 1'b1;
    slv_rdata = rd;
    step();
    chk("resp_m_ack", 64'(m_ack), 64'(2'b01 << mst));
    chk("resp_m_rdata", 64'(m_rdata), 64'(rd));
    chk("resp_m_err", 64'(m_err), 64'd0);
    chk("resp_slv_req", 64'(slv_req), 64'd0);
    slv_ack = 1'b0;
    step();
    chk("idle_m_ack", 64'(m_ack), 64'd0);
  endtask
  initial begin
    reset = 1'b0;
    m_req = 2'b11;
    m_cmd = 2'b00;
    m_addr = {A1, A0};
    m_wdata = {W1, W0};
    slv_ack = 1'b0;
    slv_rdata = '0;
    step();
    step();
    chk("rst_slv_req", 64'(slv_req), 64'd0);
    chk("rst_m_ack", 64'(m_ack), 64'd0);
    chk("rst_m_rdata", 64'(m_rdata), 64'd0);
    chk("rst_m_err", 64'(m_err), 64'd0);
    chk("rst_slv_addr", 64'(slv_addr), 64'd0);
    reset = 1'b1;
    // continuous requests from both masters: grants alternate every 3 cycles
    for (int i = 0; i < 4; i++) serve(i % 2, (i % 2) ? A1 : A0, 32'h5500_0000 + 32'(i));
    m_req = 2'b10;
    m_cmd = 2'b00;
    m_addr = {32'hA000_1000, A0};
    serve(1, 32'hA000_1000, 32'h1234_5678);
    chk("rd_slv_cmd_held", 64'(slv_cmd), 64'd0);
    m_req = 2'b01;
    m_cmd = 2'b01;
    m_addr = {A1, A0};
    step();
    chk("wr_slv_req", 64'(slv_req), 64'd1);
    chk("wr_slv_cmd", 64'(slv_cmd), 64'd1);
    chk("wr_slv_wdata", 64'(slv_wdata), 64'(W0));
    for (int i = 0; i < 15; i++) step();
    chk("to_last_busy_req", 64'(slv_req), 64'd1);
    chk("to_last_busy_ack", 64'(m_ack), 64'd0);
    step();
    chk("to_slv_req", 64'(slv_req), 64'd0);
    chk("to_m_ack", 64'(m_ack), 64'd1);
    chk("to_m_err", 64'(m_err), 64'd1);
    chk("to_m_rdata", 64'(m_rdata), 64'hDEAD_BEEF);
    m_req = 2'b00;
    slv_ack = 1'b1;
    slv_rdata = 32'h0BAD_0BAD;
    step();
    chk("late_ack_idle", 64'(m_ack), 64'd0);
    slv_ack = 1'b0;
    step();
    chk("late_ack_none", 64'(m_ack), 64'd0);
    chk("late_slv_req", 64'(slv_req), 64'd0);
    chk("hold_m_err", 64'(m_err), 64'd1);
    chk("hold_m_rdata", 64'(m_rdata), 64'hDEAD_BEEF);
    m_req = 2'b01;
    step();
    chk("race_slv_req", 64'(slv_req), 64'd1);
    for (int i = 0; i < 15; i++) step();
    slv_ack = 1'b1;
    slv_rdata = 32'hCAFE_0005;
    step();
    chk("race_m_ack", 64'(m_ack), 64'd1);
    chk("race_m_err", 64'(m_err), 64'd0);
    chk("race_m_rdata", 64'(m_rdata), 64'hCAFE_0005);
    slv_ack = 1'b0;
    m_req = 2'b11;
    step();
    step();
    chk("pre_rst_slv_req", 64'(slv_req), 64'd1);
    chk("pre_rst_slv_addr", 64'(slv_addr), 64'(A1));
    step();
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_slv_req", 64'(slv_req), 64'd0);
    chk("mid_rst_m_ack", 64'(m_ack), 64'd0);
    step();
    chk("in_rst_slv_addr", 64'(slv_addr), 64'd0);
    reset = 1'b1;
    step();
    chk("post_rst_slv_req", 64'(slv_req), 64'd1);
    chk("post_rst_master0", 64'(slv_addr), 64'(A0));
    chk("post_rst_m_ack", 64'(m_ack), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
